// File: rtl/scan_sel_gen.sv
// scan_sel_gen: time-multiplexed scan sequencer for a 3-to-8 one-hot decoder.
// Walks sel round-robin through the enabled positions with a programmable
// dwell, inserts a blanking gap between positions, and presents the stored
// digit for the current position.
module scan_sel_gen #(
   parameter int DIV_W     = 16,
   parameter int DATA_W    = 4,
   parameter int BLANK_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DIV_W-1:0]  div,
   input  logic [7:0]        active_mask,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [2:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [2:0]        sel,
   output logic              sel_valid,
   output logic [DATA_W-1:0] digit,
   output logic              tick
);

   localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [DIV_W-1:0]    cnt_r, cnt_nxt_s;
   logic [DIV_W-1:0]    div_r, div_nxt_s;
   logic [BLK_W-1:0]    blk_r, blk_nxt_s;
   logic [2:0]          sel_r, sel_nxt_s;
   logic                tick_r, tick_nxt_s;
   logic                sel_valid_r;
   logic                wr_ready_r;
   logic                run_ok_s;
   logic                wr_fire_s;
   logic [DATA_W-1:0]   mem_r [8];

   // Nearest active position after p (skip_self=1) or starting at p
   // (skip_self=0), wrapping 7->0. Farther candidates are visited first so
   // the nearest match overwrites them. Returns p when nothing is enabled.
   function automatic logic [2:0] find_active(input logic [2:0] p,
                                              input logic [7:0] m,
                                              input logic       skip_self);
      logic [2:0] res;
      logic [2:0] q;
      res = p;
      for (int i = 8; i >= 0; i--) begin
         q = p + 3'(i);
         if (((skip_self == 1'b1) && (i >= 1)) || ((skip_self == 1'b0) && (i <= 7))) begin
            if (m[q] == 1'b1) begin
               res = q;
            end else begin
               res = res;
            end
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign run_ok_s  = en && (active_mask != 8'h00);
   assign wr_fire_s = wr_valid && wr_ready_r;

   // Next-state and next-output logic for the scan FSM.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      div_nxt_s   = div_r;
      blk_nxt_s   = blk_r;
      sel_nxt_s   = sel_r;
      tick_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_nxt_s = '0;
            blk_nxt_s = '0;
            if (run_ok_s) begin
               sel_nxt_s   = find_active(sel_r, active_mask, 1'b0);
               div_nxt_s   = div;
               tick_nxt_s  = 1'b1;
               state_nxt_s = ST_SHOW;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHOW: begin
            if (!run_ok_s) begin
               cnt_nxt_s   = '0;
               blk_nxt_s   = '0;
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == div_r) begin
               cnt_nxt_s   = '0;
               blk_nxt_s   = '0;
               state_nxt_s = ST_BLANK;
            end else begin
               cnt_nxt_s = cnt_r + DIV_W'(1);
            end
         end
         ST_BLANK: begin
            if (!run_ok_s) begin
               cnt_nxt_s   = '0;
               blk_nxt_s   = '0;
               state_nxt_s = ST_IDLE;
            end else if (blk_r == BLK_LAST) begin
               // Mask is looked at only here, so a mid-dwell change never
               // cuts short the position being shown.
               sel_nxt_s   = find_active(sel_r, active_mask, 1'b1);
               div_nxt_s   = div;
               tick_nxt_s  = 1'b1;
               cnt_nxt_s   = '0;
               blk_nxt_s   = '0;
               state_nxt_s = ST_SHOW;
            end else begin
               blk_nxt_s = blk_r + BLK_W'(1);
            end
         end
         default: begin
            cnt_nxt_s   = '0;
            blk_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, counters and registered scan outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         div_r       <= '0;
         blk_r       <= '0;
         sel_r       <= 3'd0;
         tick_r      <= 1'b0;
         sel_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         div_r       <= div_nxt_s;
         blk_r       <= blk_nxt_s;
         sel_r       <= sel_nxt_s;
         tick_r      <= tick_nxt_s;
         sel_valid_r <= (state_nxt_s == ST_SHOW);
      end
   end

   // Write port: ready rises on the first edge out of reset and stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ready_r <= 1'b0;
      end else begin
         wr_ready_r <= 1'b1;
      end
   end

   // Digit store, cleared by reset and written on every accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_fire_s) begin
         mem_r[wr_addr] <= wr_data;
      end else begin
         mem_r[wr_addr] <= mem_r[wr_addr];
      end
   end

   assign wr_ready  = wr_ready_r;
   assign sel       = sel_r;
   assign sel_valid = sel_valid_r;
   assign tick      = tick_r;
   assign digit     = mem_r[sel_r];

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: table-driven store/reset vectors
// plus hand-written sequences for the scan timing corner cases.
module tb_scan_sel_gen;

   localparam int DIV_W  = 16;
   localparam int DATA_W = 4;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic [DIV_W-1:0]  div;
   logic [7:0]        active_mask;
   logic              wr_valid;
   logic              wr_ready;
   logic [2:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [2:0]        sel;
   logic              sel_valid;
   logic [DATA_W-1:0] digit;
   logic              tick;

   int checks;
   int errors;

   typedef struct {
      logic              wv;
      logic [2:0]        wa;
      logic [DATA_W-1:0] wd;
      logic [2:0]        e_sel;
      logic              e_valid;
      logic              e_tick;
      logic [DATA_W-1:0] e_digit;
      logic              e_ready;
   } vec_t;

   vec_t vecs [10];

   scan_sel_gen #(.DIV_W(DIV_W), .DATA_W(DATA_W), .BLANK_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .div(div), .active_mask(active_mask),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .sel(sel), .sel_valid(sel_valid), .digit(digit), .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] e_sel, input logic e_valid,
                          input logic e_tick, input logic [DATA_W-1:0] e_digit,
                          input logic e_ready);
      chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
      chk({tag, ".sel_valid"}, 32'(sel_valid), 32'(e_valid));
      chk({tag, ".tick"}, 32'(tick), 32'(e_tick));
      chk({tag, ".digit"}, 32'(digit), 32'(e_digit));
      chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(e_ready));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_sel;
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      en          = 1'b0;
      div         = 16'd3;
      active_mask = 8'hFF;
      wr_valid    = 1'b0;
      wr_addr     = 3'd0;
      wr_data     = 4'd0;

      // Store table: one idle row, eight back-to-back writes mem[i]=i+1, one idle row.
      vecs[0] = '{1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         vecs[i+1] = '{1'b1, 3'(i), 4'(i + 1), 3'd0, 1'b0, 1'b0, 4'd1, 1'b1};
      end
      vecs[9] = '{1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b1};

      // Reset state while rst_n is held low.
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: store writes with scanning disabled.
      for (int v = 0; v < 10; v++) begin
         wr_valid = vecs[v].wv;
         wr_addr  = vecs[v].wa;
         wr_data  = vecs[v].wd;
         cyc();
         chk_all($sformatf("store[%0d]", v), vecs[v].e_sel, vecs[v].e_valid,
                 vecs[v].e_tick, vecs[v].e_digit, vecs[v].e_ready);
      end

      // Test 2: full mask, div=3 -> 4 show + 2 blank per position, 0..7 then 0.
      en = 1'b1;
      for (int p = 0; p < 9; p++) begin
         for (int c = 0; c < 6; c++) begin
            cyc();
            exp_sel = 3'(p % 8);
            chk_all($sformatf("full p%0d c%0d", p, c), exp_sel, (c < 4), (c == 0),
                    4'(exp_sel) + 4'd1, 1'b1);
         end
      end

      // Test 3: sparse mask from sel=0, div=0 -> 2,7,2,7 with a 3-cycle period.
      en = 1'b0;
      cyc();
      chk_all("stop_to_zero", 3'd0, 1'b0, 1'b0, 4'd1, 1'b1);
      active_mask = 8'b1000_0100;
      div         = 16'd0;
      en          = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 3; c++) begin
            cyc();
            exp_sel = (k % 2 == 0) ? 3'd2 : 3'd7;
            chk_all($sformatf("sparse k%0d c%0d", k, c), exp_sel, (c == 0), (c == 0),
                    4'(exp_sel) + 4'd1, 1'b1);
         end
      end

      // Test 4: mask shrinks to position 0 while sel=5 is mid-dwell.
      en = 1'b0;
      cyc();
      chk("idle_hold7.sel", 32'(sel), 32'd7);
      active_mask = 8'b0010_0000;
      div         = 16'd3;
      en          = 1'b1;
      cyc();
      chk_all("pos5 c0", 3'd5, 1'b1, 1'b1, 4'd6, 1'b1);
      active_mask = 8'b0000_0001;
      for (int c = 1; c < 6; c++) begin
         cyc();
         chk_all($sformatf("pos5 c%0d", c), 3'd5, (c < 4), 1'b0, 4'd6, 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 6; c++) begin
            cyc();
            chk_all($sformatf("only0 k%0d c%0d", k, c), 3'd0, (c < 4), (c == 0), 4'd1, 1'b1);
         end
      end

      // Test 5: en dropped mid-SHOW at sel=3, then re-enabled.
      en = 1'b0;
      cyc();
      active_mask = 8'b0000_1000;
      en          = 1'b1;
      cyc();
      chk_all("pos3 c0", 3'd3, 1'b1, 1'b1, 4'd4, 1'b1);
      cyc();
      chk_all("pos3 c1", 3'd3, 1'b1, 1'b0, 4'd4, 1'b1);
      en = 1'b0;
      for (int c = 0; c < 2; c++) begin
         cyc();
         chk_all($sformatf("halt3 c%0d", c), 3'd3, 1'b0, 1'b0, 4'd4, 1'b1);
      end
      active_mask = 8'hFF;
      en          = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cyc();
         chk_all($sformatf("resume3 c%0d", c), 3'd3, (c < 4), (c == 0), 4'd4, 1'b1);
      end
      cyc();
      chk_all("pos4 c0", 3'd4, 1'b1, 1'b1, 4'd5, 1'b1);

      // Test 6: write to the displayed address, then async reset mid-BLANK.
      wr_valid = 1'b1;
      wr_addr  = 3'd4;
      wr_data  = 4'd9;
      cyc();
      wr_valid = 1'b0;
      chk_all("wr_shown c1", 3'd4, 1'b1, 1'b0, 4'd9, 1'b1);
      for (int c = 2; c < 5; c++) begin
         cyc();
         chk_all($sformatf("wr_shown c%0d", c), 3'd4, (c < 4), 1'b0, 4'd9, 1'b1);
      end
      en    = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk_all("post_rst", 3'd0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("post_rst.mem4", 32'(dut.mem_r[4]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
